// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: AHB5 subordinate serving a single-cycle word RAM.
// Provides programmable wait states, two-phase ERROR responses for illegal
// accesses and, when AHB_SRAM_RESPONDER_EXCL_EN is defined, a per-master
// exclusive-access monitor that drives hexokay.
module ahb_sram_responder #(
   parameter int unsigned W_ADDR      = 32,
   parameter int unsigned W_DATA      = 32,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned N_MASTERS   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hsel,
   input  logic [W_ADDR-1:0] haddr,
   input  logic              hwrite,
   input  logic [1:0]        htrans,
   input  logic [2:0]        hsize,
   input  logic [3:0]        hprot,
   input  logic [7:0]        hmaster,
   input  logic              hexcl,
   input  logic              hready,
   output logic              hready_resp,
   output logic              hresp,
   output logic              hexokay,
   input  logic [W_DATA-1:0] hwdata,
   output logic [W_DATA-1:0] hrdata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [AW-1:0]       word_q, word_d;
   logic [1:0]          off_q, off_d;
   logic [1:0]          size_q, size_d;
   logic                write_q, write_d;

   logic                accept;
   logic                err_flag;
   logic                misaligned;
   logic                out_of_range;
   logic                mem_we;
   logic [3:0]          strb;

   logic [W_DATA-1:0]   mem_q [DEPTH];

   // Address-phase qualification and legality of the incoming transfer
   always_comb begin
      accept       = hsel && hready && htrans[1] && hready_resp;
      misaligned   = 1'b0;
      if (hsize == 3'd1) begin
         misaligned = haddr[0];
      end else if (hsize == 3'd2) begin
         misaligned = (haddr[1:0] != 2'b00);
      end
      // DEPTH is a power of two, so any bit above the RAM window is out of range
      out_of_range = |(haddr >> (AW + 2));
      err_flag     = (hsize > 3'd2) || misaligned || out_of_range;
   end

   // Next-state, wait counter and address-phase capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      off_d   = off_q;
      size_d  = size_q;
      write_d = write_q;
      case (state_q)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (accept) begin
               word_d  = haddr[AW+1:2];
               off_d   = haddr[1:0];
               size_d  = hsize[1:0];
               write_d = hwrite;
               cnt_d   = WS_LOAD;
               if (err_flag) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and captured address-phase registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         off_q   <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         off_q   <= off_d;
         size_q  <= size_d;
         write_q <= write_d;
      end
   end

   // Byte-lane strobes from the captured size and byte offset
   always_comb begin
      strb = 4'b0000;
      case (size_q)
         2'd0:    strb = 4'b0001 << off_q;
         2'd1:    strb = off_q[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
   end

`ifdef AHB_SRAM_RESPONDER_EXCL_EN
   logic                excl_q, excl_d;
   logic [MW-1:0]       mst_q, mst_d;
   logic [N_MASTERS-1:0] resv_vld_q, resv_vld_d;
   logic [AW-1:0]       resv_addr_q [N_MASTERS];
   logic [AW-1:0]       resv_addr_d [N_MASTERS];
   logic                excl_ok;
   logic                unused_inputs;

   assign unused_inputs = ^{hprot, htrans[0], hmaster};

   // Exclusive attributes of the captured transfer
   always_comb begin
      excl_d = excl_q;
      mst_d  = mst_q;
      if (accept && (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2)) begin
         excl_d = hexcl;
         mst_d  = hmaster[MW-1:0];
      end
   end

   // Write permission and exclusive-okay response in the data phase
   always_comb begin
      excl_ok = resv_vld_q[mst_q] && (resv_addr_q[mst_q] == word_q);
      mem_we  = (state_q == ST_DATA) && write_q && (!excl_q || excl_ok);
      hexokay = (state_q == ST_DATA) && excl_q && (!write_q || excl_ok);
   end

   // Reservation update: exclusive reads reserve, any landed write to a
   // reserved word drops every reservation on that word
   always_comb begin
      resv_vld_d  = resv_vld_q;
      resv_addr_d = resv_addr_q;
      if (state_q == ST_DATA) begin
         if (mem_we) begin
            for (int unsigned m = 0; m < N_MASTERS; m++) begin
               if (resv_vld_q[m] && (resv_addr_q[m] == word_q)) begin
                  resv_vld_d[m] = 1'b0;
               end
            end
         end
         if (!write_q && excl_q) begin
            resv_vld_d[mst_q]  = 1'b1;
            resv_addr_d[mst_q] = word_q;
         end
      end
   end

   // Exclusive monitor registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         excl_q     <= 1'b0;
         mst_q      <= '0;
         resv_vld_q <= '0;
         for (int unsigned m = 0; m < N_MASTERS; m++) begin
            resv_addr_q[m] <= '0;
         end
      end else begin
         excl_q      <= excl_d;
         mst_q       <= mst_d;
         resv_vld_q  <= resv_vld_d;
         resv_addr_q <= resv_addr_d;
      end
   end
`else
   logic                unused_inputs;

   assign unused_inputs = ^{hprot, htrans[0], hmaster, hexcl};

   // Every write in the data phase lands; no exclusive support
   always_comb begin
      mem_we  = (state_q == ST_DATA) && write_q;
      hexokay = 1'b0;
   end
`endif

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) begin
               mem_q[word_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
         end
      end
   end

   // Bus response outputs decoded from the state
   always_comb begin
      hready_resp = 1'b1;
      hresp       = 1'b0;
      hrdata      = '0;
      case (state_q)
         ST_WAIT: hready_resp = 1'b0;
         ST_DATA: hrdata      = mem_q[word_q];
         ST_ERR1: begin
            hready_resp = 1'b0;
            hresp       = 1'b1;
         end
         ST_ERR2: hresp       = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Bench for ahb_sram_responder: two instances (0 and 2 wait states) share one
// AHB bus; the driver queues expected responses and a bus monitor checks them.
module tb_ahb_sram_responder;

`ifdef AHB_SRAM_RESPONDER_EXCL_EN
   localparam bit EXCL = 1'b1;
`else
   localparam bit EXCL = 1'b0;
`endif

   typedef struct {
      logic        rd;
      logic        err;
      logic        exok;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [7:0]  hmaster;
   logic        hexcl;
   logic [31:0] hwdata;
   logic        bus_hready;
   logic        rdy0, rsp0, exo0, rdy1, rsp1, exo1;
   logic [31:0] rd0, rd1;

   int   total = 0;
   int   bad   = 0;
   int   pend[2];
   int   waitc[2];
   int   errc[2];
   exp_t q0[$];
   exp_t q1[$];

   assign bus_hready = rdy0 & rdy1;

   ahb_sram_responder #(
      .W_ADDR(32), .W_DATA(32), .DEPTH(1024), .WAIT_STATES(0), .N_MASTERS(2)
   ) u_dut0 (
      .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
      .htrans(htrans), .hsize(hsize), .hprot(hprot), .hmaster(hmaster),
      .hexcl(hexcl), .hready(bus_hready), .hready_resp(rdy0), .hresp(rsp0),
      .hexokay(exo0), .hwdata(hwdata), .hrdata(rd0)
   );

   ahb_sram_responder #(
      .W_ADDR(32), .W_DATA(32), .DEPTH(1024), .WAIT_STATES(2), .N_MASTERS(2)
   ) u_dut2 (
      .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
      .htrans(htrans), .hsize(hsize), .hprot(hprot), .hmaster(hmaster),
      .hexcl(hexcl), .hready(bus_hready), .hready_resp(rdy1), .hresp(rsp1),
      .hexokay(exo1), .hwdata(hwdata), .hrdata(rd1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL dut%0d %s: actual=%h required=%h", k, nm, act, exp);
      end
   endtask

   // One monitor step for instance k, sampled on the falling edge
   task automatic mon_step(input int k);
      exp_t        t;
      logic        r, s, x, empty;
      logic [31:0] d;
      int          ws;
      ws = (k == 0) ? 0 : 2;
      if (k == 0) begin
         r = rdy0; s = rsp0; x = exo0; d = rd0;
      end else begin
         r = rdy1; s = rsp1; x = exo1; d = rd1;
      end
      if (rst) begin
         chk(k, "rst_ready", 32'(r), 32'd1);
         chk(k, "rst_resp", 32'(s), 32'd0);
         chk(k, "rst_exokay", 32'(x), 32'd0);
         chk(k, "rst_rdata", d, 32'd0);
         if (pend[k] != 0) begin
            if (k == 0 && q0.size() > 0) void'(q0.pop_front());
            if (k == 1 && q1.size() > 0) void'(q1.pop_front());
         end
         pend[k]  = 0;
         waitc[k] = 0;
         errc[k]  = 0;
         return;
      end
      if (pend[k] != 0) begin
         if (!r) begin
            if (s) errc[k]++;
            else   waitc[k]++;
            chk(k, "stall_exokay", 32'(x), 32'd0);
            chk(k, "stall_rdata", d, 32'd0);
         end else begin
            empty = 1'b0;
            if (k == 0) begin
               if (q0.size() == 0) empty = 1'b1; else t = q0.pop_front();
            end else begin
               if (q1.size() == 0) empty = 1'b1; else t = q1.pop_front();
            end
            if (empty) begin
               chk(k, "scoreboard_empty", 32'd1, 32'd0);
            end else begin
               chk(k, "resp", 32'(s), 32'(t.err));
               chk(k, "exokay", 32'(x), 32'(t.exok));
               chk(k, "wait_cycles", 32'(waitc[k]), t.err ? 32'd0 : 32'(ws));
               chk(k, "err1_cycles", 32'(errc[k]), t.err ? 32'd1 : 32'd0);
               if (t.err)     chk(k, "err_rdata", d, 32'd0);
               else if (t.rd) chk(k, "rdata", d, t.data);
            end
            pend[k]  = 0;
            waitc[k] = 0;
            errc[k]  = 0;
         end
      end else begin
         chk(k, "idle_ready", 32'(r), 32'd1);
         chk(k, "idle_resp", 32'(s), 32'd0);
         chk(k, "idle_exokay", 32'(x), 32'd0);
         chk(k, "idle_rdata", d, 32'd0);
      end
      if (bus_hready) pend[k] = (hsel && htrans[1]) ? 1 : 0;
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) mon_step(k);
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus_hready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus_hready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: actual=hready_low required=hready_high");
      end
   endtask

   // Present one address phase, queue its expected response, and after
   // acceptance drive its write data for the following data phase
   task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic x, input logic [7:0] m,
                        input logic e, input logic eo, input logic [31:0] d);
      exp_t t;
      t.rd = !w; t.err = e; t.exok = eo; t.data = d;
      hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
      hexcl = x; hmaster = m;
      q0.push_back(t);
      q1.push_back(t);
      wait_ready();
      @(posedge clk); #1;
      hwdata = wd;
      hsel   = 1'b0;
      htrans = 2'b00;
      hexcl  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
      issue(1'b1, a, sz, wd, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] d);
      issue(1'b0, a, 3'd2, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, d);
   endtask

   task automatic bad_acc(input logic w, input logic [31:0] a, input logic [2:0] sz);
      issue(w, a, sz, 32'hFFFF_FFFF, 1'b0, 8'd0, 1'b1, 1'b0, 32'd0);
   endtask

   initial begin
      int n;
      pend  = '{0, 0};
      waitc = '{0, 0};
      errc  = '{0, 0};
      rst = 1'b1; hsel = 1'b0; haddr = '0; hwrite = 1'b0; htrans = 2'b00;
      hsize = 3'd2; hprot = 4'h3; hmaster = 8'd0; hexcl = 1'b0; hwdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Write then immediate read of the same word
      wr(32'h10, 3'd2, 32'hDEAD_BEEF);
      rd(32'h10, 32'hDEAD_BEEF);
      wr(32'h20, 3'd2, 32'h0123_4567);
      rd(32'h20, 32'h0123_4567);

      // IDLE/BUSY transfers while selected give zero-wait OKAY
      hsel = 1'b1; htrans = 2'b01; haddr = 32'h2;
      repeat (2) @(posedge clk);
      #1 htrans = 2'b00;
      @(posedge clk);
      #1 hsel = 1'b0;

      // Byte and halfword lane strobes
      wr(32'h10, 3'd2, 32'h1122_3344);
      wr(32'h13, 3'd0, 32'hAAAA_AAAA);
      rd(32'h10, 32'hAA22_3344);
      wr(32'h12, 3'd1, 32'h5566_7788);
      rd(32'h10, 32'h5566_3344);
      wr(32'h11, 3'd0, 32'h0000_EE00);
      rd(32'h10, 32'h5566_EE44);

      // Illegal accesses: misaligned, out of range, oversize; RAM unchanged
      wr(32'h0, 3'd2, 32'h0BAD_CAFE);
      wr(32'hFFC, 3'd2, 32'hCAFE_F00D);
      bad_acc(1'b0, 32'h2, 3'd2);
      bad_acc(1'b1, 32'h1000, 3'd2);
      bad_acc(1'b1, 32'h10, 3'd3);
      bad_acc(1'b1, 32'h11, 3'd1);
      rd(32'h10, 32'h5566_EE44);
      rd(32'h0, 32'h0BAD_CAFE);
      rd(32'hFFC, 32'hCAFE_F00D);

      // Exclusive pair from master 0, then a pair broken by master 1
      wr(32'h40, 3'd2, 32'h1111_1111);
      issue(1'b0, 32'h40, 3'd2, 32'd0, 1'b1, 8'd0, 1'b0, EXCL, 32'h1111_1111);
      issue(1'b1, 32'h40, 3'd2, 32'h5, 1'b1, 8'd0, 1'b0, EXCL, 32'd0);
      rd(32'h40, 32'h5);
      issue(1'b0, 32'h40, 3'd2, 32'd0, 1'b1, 8'd0, 1'b0, EXCL, 32'h5);
      issue(1'b1, 32'h40, 3'd2, 32'h77, 1'b0, 8'd1, 1'b0, 1'b0, 32'd0);
      issue(1'b1, 32'h40, 3'd2, 32'h99, 1'b1, 8'd0, 1'b0, 1'b0, 32'd0);
      rd(32'h40, EXCL ? 32'h77 : 32'h99);

      // Asynchronous reset in the middle of a waited read
      wr(32'h80, 3'd2, 32'h1357_9BDF);
      rd(32'h80, 32'h1357_9BDF);
      #1 rst = 1'b1;
      #1;
      chk(1, "async_rst_ready", 32'(rdy1), 32'd1);
      chk(1, "async_rst_resp", 32'(rsp1), 32'd0);
      chk(1, "async_rst_exokay", 32'(exo1), 32'd0);
      chk(1, "async_rst_rdata", rd1, 32'd0);
      chk(0, "async_rst_rdata", rd0, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rd(32'h80, 32'h1357_9BDF);
      rd(32'h10, 32'h5566_EE44);

      // Drain outstanding data phases
      hsel = 1'b0; htrans = 2'b00;
      n = 0;
      @(posedge clk);
      while ((pend[0] != 0 || pend[1] != 0) && n < 40) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      chk(0, "scoreboard_left", 32'(q0.size()), 32'd0);
      chk(1, "scoreboard_left", 32'(q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
- AHB5 subordinate (responder) that serves a single-cycle-access word RAM to an AHB5 initiator such as the single-port CPU arbiter.
- Sits behind the system interconnect decode; the decoder drives hsel.
- Supports programmable wait states, two-phase ERROR responses for illegal accesses, and an optional exclusive-access monitor that drives hexokay.

Parameters:
W_ADDR, 32, address bus width
W_DATA, 32, data bus width; fixed at 32
DEPTH, 1024, RAM size in 32-bit words; power of 2
WAIT_STATES, 0, hready_resp low cycles inserted per OKAY data phase (0..15)
N_MASTERS, 2, number of exclusive reservations, indexed by hmaster[$clog2(N_MASTERS)-1:0]

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
hsel  in  1  decoder select
haddr  in  W_ADDR  address-phase address
hwrite  in  1  write transfer
htrans  in  2  transfer type; only NSEQ/SEQ (htrans[1]=1) are active
hsize  in  3  transfer size
hprot  in  4  protection; ignored
hmaster  in  8  initiator ID
hexcl  in  1  exclusive transfer
hready  in  1  bus-level hready; qualifies address phases
hready_resp  out  1  responder ready
hresp  out  1  1 = ERROR
hexokay  out  1  exclusive okay
hwdata  in  W_DATA  write data, valid in the data phase
hrdata  out  W_DATA  read data

Behaviour:
- Address phase accepted when hsel && hready && htrans[1]. Accepted phase registers addr, write, size, excl, master, err_flag.
- err_flag = hsize > 2 || misaligned (half: haddr[0]; word: haddr[1:0] != 0) || haddr >= DEPTH*4.
- States:
  - IDLE: hready_resp=1, hresp=0. Go to WAIT if accepted && !err_flag && WAIT_STATES>0; go to DATA if accepted && !err_flag && WAIT_STATES==0; go to ERR1 if accepted && err_flag.
  - WAIT: hready_resp=0; 4-bit counter loads WAIT_STATES-1 and decrements; go to DATA when it reaches 0.
  - DATA: hready_resp=1; the transfer completes this cycle. A new phase accepted on the same edge re-enters WAIT, DATA or ERR1; otherwise go to IDLE.
  - ERR1: hready_resp=0, hresp=1; go to ERR2 next cycle.
  - ERR2: hready_resp=1, hresp=1; accept the next phase as from IDLE. An errored transfer never writes RAM.
  - An IDLE/BUSY transfer, or hsel=0, gives a zero-wait OKAY with no state change.
- Write:
  - Commits on the clk edge ending DATA, using hwdata sampled in that cycle.
  - Byte strobes: byte = lane haddr[1:0]; half = lanes {haddr[1],0} and {haddr[1],1}; word = all four lanes.
- Read:
  - hrdata = mem[addr] during DATA only; otherwise 0. No byte shifting; the initiator selects lanes.
  - Write then read of the same word back-to-back returns the new data with zero hazard stall.
- Reset:
  - Async reset asserted mid-transfer forces IDLE, hready_resp=1, hresp=0, hexokay=0, hrdata=0, and clears all reservations.
  - RAM contents are not reset.
- No backpressure on hwdata. hburst is not a port: every transfer is treated as an independent single transfer.

Optional Feature:
AHB_SRAM_RESPONDER_EXCL_EN
- Defined:
  - One reservation {valid, word addr} per master.
  - Exclusive read: sets that master's reservation; hexokay=1 in DATA.
  - Exclusive write: succeeds if the master's reservation is valid and its address matches. Success writes RAM, gives hexokay=1, and clears every reservation on that word. Failure does not write, gives hexokay=0 and hresp=0.
  - Any non-exclusive write to a reserved word clears all reservations on that word.
  - hexokay is asserted only in DATA; it is 0 in every other state, including both ERR cycles.
- Undefined:
  - hexcl is ignored; exclusive writes behave as normal writes.
  - hexokay is tied to 0 and no reservation state is built.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 on the next phase -> read DATA returns 0xDEADBEEF; hready_resp stays 1 throughout.
- WAIT_STATES=2: word read of 0x20 -> hready_resp=0 for exactly 2 cycles, then 1 with hrdata = mem[8].
- Byte write 0xAA with haddr=0x13 over word 0x11223344 -> readback 0xAA223344.
- Word access to 0x2 and access to DEPTH*4 -> ERR1 (hready_resp=0, hresp=1), then ERR2 (1, 1); RAM unchanged.
- EXCL_EN, master 0: exclusive read of 0x40, then exclusive write of 0x5 -> hexokay=1 and write lands. Repeat with a master 1 normal write in between -> hexokay=0, RAM holds master 1's value.
- Assert rst during a WAIT cycle -> outputs immediately hready_resp=1, hresp=0, hexokay=0, hrdata=0; after release, the next read returns pre-reset RAM data.
